// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared types and constants for the PS/2 host-side blocks.
//   tx_state_t      : host transmitter state encoding
//   PS2_FRAME_FALLS : device clock falls in one host-to-device frame
//   CMD_SET_LEDS    : keyboard "set LEDs" command byte
//   RSP_ACK         : keyboard acknowledge response byte
//   odd_parity()    : parity bit that makes the 9-bit word odd
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [3:0] {
    IDLE,
    INHIBIT,
    WAIT_FIRST,
    DATA,
    PARITY,
    ACK,
    WAIT_IDLE,
    DONE,
    ABORT
  } tx_state_t;

  localparam int         PS2_FRAME_FALLS = 11;
  localparam logic [7:0] CMD_SET_LEDS    = 8'hED;
  localparam logic [7:0] RSP_ACK         = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ---------------------------------------------------------------------------
// ps2_line_sync
// Brings the raw PS/2 CLK and DAT line levels into the clk domain through
// two flops each and flags synced CLK 1->0 transitions.
//   clk        : system clock
//   resetN     : asynchronous active-low reset
//   i_clk_raw  : raw PS2_CLK line level
//   i_dat_raw  : raw PS2_DAT line level
//   o_clk_sync : synchronized CLK level
//   o_dat_sync : synchronized DAT level
//   o_clk_fall : one-cycle pulse on a synced CLK falling edge
// ---------------------------------------------------------------------------
module ps2_line_sync (
  input  logic clk,
  input  logic resetN,
  input  logic i_clk_raw,
  input  logic i_dat_raw,
  output logic o_clk_sync,
  output logic o_dat_sync,
  output logic o_clk_fall
);

  logic r_clk_meta;
  logic r_clk_sync;
  logic r_clk_prev;
  logic r_dat_meta;
  logic r_dat_sync;

  // Idle PS/2 lines float high, so the chain resets to 1; resetting to 0
  // would fake a rising edge (and no fall) right after reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, regardless of statement order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_clk_meta <= i_clk_raw;
      r_clk_sync <= r_clk_meta;
      r_clk_prev <= r_clk_sync;
      r_dat_meta <= i_dat_raw;
      r_dat_sync <= r_dat_meta;
    end
  end

  assign o_clk_sync = r_clk_sync;
  assign o_dat_sync = r_dat_sync;
  assign o_clk_fall = r_clk_prev & ~r_clk_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device transmitter: sends one command byte to the keyboard
// using open-drain CLK/DAT (the block only pulls low or releases).
//   clk         : system clock
//   resetN      : asynchronous active-low reset
//   tx_valid    : request to send tx_data
//   tx_data     : command byte
//   tx_ready    : idle; request accepted when tx_valid && tx_ready
//   PS2_CLK_in  : raw PS2_CLK line level
//   PS2_DAT_in  : raw PS2_DAT line level
//   ps2_clk_low : 1 = pull CLK low, 0 = release
//   ps2_dat_low : 1 = pull DAT low, 0 = release
//   tx_busy     : frame in progress (receiver ignores the lines)
//   tx_done     : one-cycle pulse, frame sent and ACKed
//   tx_error    : one-cycle pulse, NACK or timeout
// ---------------------------------------------------------------------------
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 4000,
  parameter int START_TIMEOUT  = 500000,
  parameter int FRAME_TIMEOUT  = 80000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       PS2_CLK_in,
  input  logic       PS2_DAT_in,
  output logic       ps2_clk_low,
  output logic       ps2_dat_low,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int CNT_MAX0 = (START_TIMEOUT > FRAME_TIMEOUT) ? START_TIMEOUT : FRAME_TIMEOUT;
  localparam int CNT_MAX  = (CNT_MAX0 > INHIBIT_CYCLES) ? CNT_MAX0 : INHIBIT_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] INH_REL    = CNT_W'(INHIBIT_CYCLES);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TIMEOUT - 1);

  tx_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_bit_idx, w_bit_idx_nxt;
  logic [7:0]       r_data;
  logic             r_par;
  logic             r_clk_low, w_clk_low_nxt;
  logic             r_dat_low, w_dat_low_nxt;

  logic w_clk_sync;
  logic w_dat_sync;
  logic w_clk_fall;
  logic w_accept;
  logic w_frame_expired;

  ps2_line_sync u_sync (
    .clk        (clk),
    .resetN     (resetN),
    .i_clk_raw  (PS2_CLK_in),
    .i_dat_raw  (PS2_DAT_in),
    .o_clk_sync (w_clk_sync),
    .o_dat_sync (w_dat_sync),
    .o_clk_fall (w_clk_fall)
  );

  assign w_accept        = tx_valid && (r_state == IDLE);
  // One counter serves all phases; it is cleared on entry to INHIBIT,
  // WAIT_FIRST and DATA, and keeps running from DATA through WAIT_IDLE.
  assign w_frame_expired = (r_cnt == FRAME_LAST);

  // NOTE: every variable written here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + 1'b1;
    w_bit_idx_nxt = r_bit_idx;
    w_clk_low_nxt = r_clk_low;
    w_dat_low_nxt = r_dat_low;

    unique case (r_state)
      IDLE: begin
        w_cnt_nxt     = '0;
        w_bit_idx_nxt = '0;
        w_clk_low_nxt = 1'b0;
        w_dat_low_nxt = 1'b0;
        if (w_accept) begin
          w_state_nxt   = INHIBIT;
          w_clk_low_nxt = 1'b1;
        end
      end

      // Line activity is ignored here: holding CLK low aborts any frame the
      // device was sending.
      INHIBIT: begin
        if (r_cnt == INH_LAST) begin
          w_dat_low_nxt = 1'b1;              // start bit, set while CLK still low
        end
        if (r_cnt == INH_REL) begin
          w_clk_low_nxt = 1'b0;
          w_cnt_nxt     = '0;
          w_state_nxt   = WAIT_FIRST;
        end
      end

      WAIT_FIRST: begin
        if (w_clk_fall) begin
          // Fall 1 presents data[0]; bit_idx tracks the bit on the line.
          w_dat_low_nxt = ~r_data[0];
          w_bit_idx_nxt = '0;
          w_cnt_nxt     = '0;
          w_state_nxt   = DATA;
        end else if (r_cnt == START_LAST) begin
          w_clk_low_nxt = 1'b0;
          w_dat_low_nxt = 1'b0;
          w_state_nxt   = ABORT;
        end
      end

      DATA: begin
        if (w_frame_expired) begin
          w_clk_low_nxt = 1'b0;
          w_dat_low_nxt = 1'b0;
          w_state_nxt   = ABORT;
        end else if (w_clk_fall) begin
          if (r_bit_idx == 4'd7) begin
            w_dat_low_nxt = ~r_par;
            w_bit_idx_nxt = 4'd8;
            w_state_nxt   = PARITY;
          end else begin
            w_dat_low_nxt = ~r_data[r_bit_idx[2:0] + 3'd1];
            w_bit_idx_nxt = r_bit_idx + 4'd1;
          end
        end
      end

      PARITY: begin
        if (w_frame_expired) begin
          w_clk_low_nxt = 1'b0;
          w_dat_low_nxt = 1'b0;
          w_state_nxt   = ABORT;
        end else if (w_clk_fall) begin
          w_dat_low_nxt = 1'b0;              // stop bit: release DAT
          w_bit_idx_nxt = 4'd9;
          w_state_nxt   = ACK;
        end
      end

      ACK: begin
        if (w_frame_expired) begin
          w_clk_low_nxt = 1'b0;
          w_dat_low_nxt = 1'b0;
          w_state_nxt   = ABORT;
        end else if (w_clk_fall) begin
          w_bit_idx_nxt = 4'(PS2_FRAME_FALLS - 1);
          w_state_nxt   = w_dat_sync ? ABORT : WAIT_IDLE;
        end
      end

      WAIT_IDLE: begin
        if (w_frame_expired) begin
          w_clk_low_nxt = 1'b0;
          w_dat_low_nxt = 1'b0;
          w_state_nxt   = ABORT;
        end else if (w_clk_sync && w_dat_sync) begin
          w_state_nxt = DONE;
        end
      end

      DONE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end

      ABORT: begin
        w_cnt_nxt     = '0;
        w_clk_low_nxt = 1'b0;
        w_dat_low_nxt = 1'b0;
        w_state_nxt   = IDLE;
      end

      default: begin
        w_cnt_nxt     = '0;
        w_clk_low_nxt = 1'b0;
        w_dat_low_nxt = 1'b0;
        w_state_nxt   = IDLE;
      end
    endcase
  end

  // Line drivers are flops so the open-drain enables never glitch; the
  // asynchronous reset still releases both lines at once.
  // NOTE: the byte/parity holding registers are reset along with the control
  // state; they are tiny and this keeps them X-free before the first request.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_data    <= '0;
      r_par     <= 1'b0;
      r_clk_low <= 1'b0;
      r_dat_low <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_clk_low <= w_clk_low_nxt;
      r_dat_low <= w_dat_low_nxt;
      if (w_accept) begin
        r_data <= tx_data;
        r_par  <= odd_parity(tx_data);
      end
    end
  end

  assign tx_ready    = (r_state == IDLE);
  assign tx_busy     = (r_state != IDLE);
  assign tx_done     = (r_state == DONE);
  assign tx_error    = (r_state == ABORT);
  assign ps2_clk_low = r_clk_low;
  assign ps2_dat_low = r_dat_low;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Directed bench for ps2_host_tx with a simple PS/2 device model that
// generates the line clock (40 clk per half-period) and samples DAT on
// rising edges. Expected frame words are hand-computed:
//   bits[7:0] = data LSB first, bits[8] = parity, bits[9] = stop.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       ps2_clk_low;
  logic       ps2_dat_low;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  logic line_clk;
  logic line_dat;

  // Wired-AND open-drain lines with pull-ups.
  assign line_clk = dev_clk & ~ps2_clk_low;
  assign line_dat = dev_dat & ~ps2_dat_low;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int acc_cnt = 0;

  ps2_host_tx #(
    .INHIBIT_CYCLES (8),
    .START_TIMEOUT  (200),
    .FRAME_TIMEOUT  (2000)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .PS2_CLK_in  (line_clk),
    .PS2_DAT_in  (line_dat),
    .ps2_clk_low (ps2_clk_low),
    .ps2_dat_low (ps2_dat_low),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_error    (tx_error)
  );

  always #5 clk = ~clk;

  // Pulse and acceptance counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
    if (resetN && tx_valid && tx_ready) acc_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request and check acceptance latency.
  task automatic send(input logic [7:0] d);
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    check("send_ready", tx_ready, 1'b1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    @(negedge clk);
    check("send_ready_drop", tx_ready, 1'b0);
    check("send_clk_low", ps2_clk_low, 1'b1);
  endtask

  // Device side: wait for the host's inhibit/release, check the start bit,
  // then clock `falls` edges. Fall 11 carries the ACK unless nack is set.
  task automatic dev_frame(input bit nack, input int falls, output logic [9:0] bits);
    int n;
    bits = '0;
    n = 0;
    while (!ps2_clk_low && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (ps2_clk_low && n < 100) begin @(negedge clk); n++; end
    check("host_release_clk", {31'd0, ps2_clk_low}, 32'd0);
    check("start_bit", line_dat, 1'b0);
    repeat (HALF) @(negedge clk);
    for (int k = 1; k <= falls; k++) begin
      dev_clk = 1'b0;
      if (k == 11 && !nack) dev_dat = 1'b0;
      repeat (HALF) @(negedge clk);
      if (k <= 10) bits[k-1] = line_dat;
      dev_clk = 1'b1;
      if (k == 11) dev_dat = 1'b1;
      else repeat (HALF) @(negedge clk);
    end
  endtask

  initial begin
    logic [9:0] bits;
    int d0, e0, a0, n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_clk_low", ps2_clk_low, 1'b0);
    check("rst_dat_low", ps2_dat_low, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_error", tx_error, 1'b0);
    @(posedge clk); #1 resetN = 1'b1;

    // 0xED, ACKed: data 1,0,1,1,0,1,1,1 parity 1 stop 1
    d0 = done_cnt; e0 = err_cnt;
    send(CMD_SET_LEDS);
    check("ed_busy", tx_busy, 1'b1);
    dev_frame(1'b0, 11, bits);
    check("ed_bits", bits, 10'h3ED);
    repeat (10) @(negedge clk);
    check("ed_done", done_cnt - d0, 1);
    check("ed_error", err_cnt - e0, 0);
    check("ed_idle", tx_ready, 1'b1);

    // 0x07: data 1,1,1,0,0,0,0,0 parity 0
    d0 = done_cnt;
    send(8'h07);
    dev_frame(1'b0, 11, bits);
    check("x07_bits", bits, 10'h207);
    repeat (10) @(negedge clk);
    check("x07_done", done_cnt - d0, 1);

    // 0x00: parity 1
    d0 = done_cnt;
    send(8'h00);
    dev_frame(1'b0, 11, bits);
    check("x00_bits", bits, 10'h300);
    repeat (10) @(negedge clk);
    check("x00_done", done_cnt - d0, 1);

    // Device never clocks: abort 200 cycles after CLK release
    d0 = done_cnt; e0 = err_cnt;
    send(8'h55);
    n = 0;
    while (ps2_clk_low && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (!tx_error && n < 400) begin n++; @(negedge clk); end
    check("to_cycles", n, 200);
    check("to_error", tx_error, 1'b1);
    check("to_clk_rel", ps2_clk_low, 1'b0);
    check("to_dat_rel", ps2_dat_low, 1'b0);
    @(negedge clk);
    check("to_ready", tx_ready, 1'b1);
    check("to_err_cnt", err_cnt - e0, 1);
    check("to_no_done", done_cnt - d0, 0);

    // NACK on fall 11
    d0 = done_cnt; e0 = err_cnt;
    send(CMD_SET_LEDS);
    dev_frame(1'b1, 11, bits);
    check("nack_bits", bits, 10'h3ED);
    repeat (10) @(negedge clk);
    check("nack_error", err_cnt - e0, 1);
    check("nack_no_done", done_cnt - d0, 0);

    // Reset in the low phase of fall 5 (data[4]=0 of 0xED is on the line)
    send(CMD_SET_LEDS);
    dev_frame(1'b0, 4, bits);
    dev_clk = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_dat_low", ps2_dat_low, 1'b1);
    resetN = 1'b0;
    #1;
    check("mid_rst_clk", ps2_clk_low, 1'b0);
    check("mid_rst_dat", ps2_dat_low, 1'b0);
    check("mid_rst_ready", tx_ready, 1'b1);
    dev_clk = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 resetN = 1'b1;
    @(negedge clk);
    check("post_rst_ready", tx_ready, 1'b1);
    d0 = done_cnt; e0 = err_cnt;
    send(CMD_SET_LEDS);
    dev_frame(1'b0, 11, bits);
    check("post_rst_bits", bits, 10'h3ED);
    repeat (10) @(negedge clk);
    check("post_rst_done", done_cnt - d0, 1);
    check("post_rst_error", err_cnt - e0, 0);

    // tx_valid held high: 0xED then 0x02, exactly two frames
    d0 = done_cnt; a0 = acc_cnt;
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = CMD_SET_LEDS;
    n = 0;
    do begin @(negedge clk); n++; end while (tx_ready && n < 10);
    check("hold_accept1", tx_ready, 1'b0);
    tx_data = 8'h02;
    dev_frame(1'b0, 11, bits);
    check("hold_bits1", bits, 10'h3ED);
    n = 0;
    while (!tx_done && n < 20) begin @(negedge clk); n++; end
    check("hold_done1", tx_done, 1'b1);
    check("hold_done_not_ready", tx_ready, 1'b0);
    check("hold_done_no_inhibit", ps2_clk_low, 1'b0);
    @(negedge clk);
    check("hold_idle_ready", tx_ready, 1'b1);
    @(negedge clk);
    check("hold_inhibit2", ps2_clk_low, 1'b1);
    check("hold_busy2", tx_ready, 1'b0);
    tx_valid = 1'b0;
    dev_frame(1'b0, 11, bits);
    check("hold_bits2", bits, 10'h202);
    repeat (10) @(negedge clk);
    check("hold_done_cnt", done_cnt - d0, 2);
    check("hold_acc_cnt", acc_cnt - a0, 2);
    check("hold_idle_end", tx_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
